screen_row_streamer: RTL
========================

// Module: screen_row_streamer
// PURPOSE
//  Consumes the composited board (game_state_t from the piece-overlay stage).
//  Snapshots it on request and streams it row by row, over a valid/ready handshake, to the display driver.
//  Decouples game-logic timing from display timing: the board may change freely after the snapshot edge.
// PARAMETERS
//  COLS    10  board width; bits per row word
//  ROWS    20  board height; beats per full frame
//  IDX_W   5   row index width, $clog2(ROWS)
// PORTS
//  clk         in   1          system clock
//  reset_n     in   1          asynchronous, active-low reset
//  in_state    in   game_state_t  composited board; screen[x][y]
//  frame_req   in   1          one-cycle pulse: send current in_state
//  row_valid   out  1          row beat available
//  row_ready   in   1          downstream accepts beat when row_valid && row_ready
//  row_idx     out  IDX_W      row number y of current beat
//  row_data    out  COLS       bit x = screen[x][row_idx]
//  row_last    out  1          current beat is final beat of frame
//  busy        out  1          frame in progress (not IDLE)
//  frame_done  out  1          one-cycle pulse after frame completes
// BEHAVIOUR
//  - Reset (async, reset_n=0) values:
//    - outputs row_valid=0, row_idx=0, row_data=0, row_last=0, busy=0, frame_done=0
//    - internal: FSM=IDLE, snapshot=0, pending=0
//  - FSM IDLE->STREAM->DONE->IDLE.
//  - IDLE, on frame_req (or pending=1):
//    - copy in_state.screen into snapshot at that edge; clear pending; y=0
//    - go to STREAM; row_valid=1 on the next cycle
//    - latency frame_req -> first row_valid = 1 cycle.
//  - STREAM:
//    - row_valid=1; row_idx=y; row_data from snapshot; all held stable until accepted
//    - accept: y++ (rows 0..ROWS-1, top first)
//    - row_last=1 when y==ROWS-1; accepting that beat -> DONE
//    - rate: one beat per cycle with row_ready tied high
//    - row_ready=0 stalls indefinitely; no timeout, no data change
//  - DONE: row_valid=0; frame_done=1 for exactly this cycle; next state IDLE.
//    - back-to-back frames: frame_req -> IDLE -> STREAM gap is 1 idle cycle
//  - frame_req while busy:
//    - sets pending; multiple requests collapse to one
//    - serviced on the IDLE cycle after DONE, snapshotting in_state at that edge, not at request time
//  - frame_req in the same cycle the FSM enters IDLE (DONE->IDLE edge):
//    - sets pending
//  - row_ready while row_valid=0 has no effect.
//  - Reset mid-frame: aborts immediately to reset values; no frame_done; pending lost.
//  - busy = (FSM != IDLE); combinational from state register.
// CONFIGURATION
//  DIRTY_ROWS_EN defined:
//    - keeps a copy of the last frame actually sent (cleared by reset)
//    - at snapshot, dirty[y] = snapshot row != sent row
//    - STREAM visits y sequentially but emits beats only for dirty rows
//    - clean rows cost 1 cycle each with row_valid=0
//    - row_last on the dirty beat with no higher dirty y; sent copy updated per accepted beat
//    - first frame after reset sends every non-zero row (sent copy resets to 0)
//    - zero dirty rows: no beats; frame_done pulses after ROWS+1 cycles
//  DIRTY_ROWS_EN undefined:
//    - every frame sends all ROWS rows; no sent copy stored
// TESTING
//  1. reset; in_state.screen[3][0]=1, frame_req, row_ready=1 -> beats y=0..19 on 20 consecutive cycles:
//     - row 0 data=10'h008, all other rows 0
//     - row_last only at y=19; frame_done 1 cycle later
//  2. Hold row_ready=0 for 5 cycles at y=7 -> row_idx=7, row_data constant, row_valid=1 throughout;
//     resumes at y=8 after accept.
//  3. Change in_state the cycle after frame_req -> streamed data equals pre-change board.
//  4. frame_req pulsed 3x during a frame -> exactly one extra frame follows, started 1 cycle after frame_done.
//  5. reset_n low at y=10 -> all outputs 0 asynchronously; no frame_done.
//     Next frame_req restarts at y=0.
//  6. DIRTY_ROWS_EN: send frame, then set screen[0][19]=1 and frame_req -> single beat y=19,
//     data=10'h001, row_last=1.
//     Same board again -> no beats, frame_done only.

Source files
------------

// File: rtl/screen_row_streamer.sv
// Snapshots the composited board on frame_req and streams it one row per beat (DIRTY_ROWS_EN: only changed rows).
// Latency: frame_req -> first row_valid 1 cycle; one beat per cycle with row_ready high; frame_done the cycle after the last row.
// Backpressure: row_ready low holds the current beat indefinitely; requests while busy collapse into one pending frame.
module screen_row_streamer #(
  parameter int COLS  = 10,
  parameter int ROWS  = 20,
  parameter int IDX_W = $clog2(ROWS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [COLS-1:0][ROWS-1:0] in_state,   // screen field of game_state_t, indexed [x][y]
  input  logic                      frame_req,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic [IDX_W-1:0]          row_idx,
  output logic [COLS-1:0]           row_data,
  output logic                      row_last,
  output logic                      busy,
  output logic                      frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_e;

  state_e                    state_q;
  logic [IDX_W-1:0]          y_q;
  logic [ROWS-1:0][COLS-1:0] snap_q;      // snapshot stored row-major: snap_q[y][x]
  logic                      pending_q;
  logic                      row_valid_q;
  logic [COLS-1:0]           row_data_q;
  logic                      row_last_q;
  logic                      done_q;

  logic [ROWS-1:0][COLS-1:0] in_rows;     // in_state transposed to row words
  logic [ROWS-1:0]           dirty_new;   // rows to emit if a snapshot were taken this edge
  logic [ROWS-1:0]           dirty_cur;   // rows to emit for the frame in flight
  logic                      start;
  logic                      advance;
  logic                      at_end;
  logic [IDX_W-1:0]          nxt_idx;
  logic [ROWS-1:0]           nxt_map;
  logic [COLS-1:0]           nxt_row;
  logic                      nxt_hi;
  logic                      nxt_vld;
  logic                      nxt_last;

  // Transpose the board so each row word is bit x = screen[x][y].
  always_comb begin
    in_rows = '0;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        in_rows[y][x] = in_state[x][y];
      end
    end
  end

  assign start   = (state_q == ST_IDLE) && (frame_req || pending_q);
  assign advance = !row_valid_q || row_ready;
  assign at_end  = (y_q == IDX_W'(ROWS - 1));

`ifdef DIRTY_ROWS_EN
  logic [ROWS-1:0][COLS-1:0] sent_q;
  logic [ROWS-1:0]           dirty_q;
  logic                      accept;

  assign accept    = row_valid_q && row_ready;
  assign dirty_cur = dirty_q;

  // A row is dirty when the new snapshot differs from what the display last received.
  always_comb begin
    dirty_new = '0;
    for (int y = 0; y < ROWS; y++) begin
      dirty_new[y] = (in_rows[y] != sent_q[y]);
    end
  end

  // Capture the dirty map at the snapshot edge; record each row once downstream takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sent_q  <= '0;
      dirty_q <= '0;
    end else begin
      if (start) begin
        dirty_q <= dirty_new;
      end
      if (accept) begin
        sent_q[y_q] <= row_data_q;
      end
    end
  end
`else
  assign dirty_new = '1;
  assign dirty_cur = '1;
`endif

  // Next beat: row 0 of the live board at the snapshot edge, else the following snapshot row.
  always_comb begin
    nxt_idx = '0;
    nxt_map = dirty_new;
    nxt_row = in_rows[0];
    nxt_hi  = 1'b0;
    if (!start) begin
      nxt_map = dirty_cur;
      nxt_row = '0;
      if (!at_end) begin
        nxt_idx = y_q + 1'b1;
        nxt_row = snap_q[nxt_idx];
      end
    end
    for (int i = 0; i < ROWS; i++) begin
      if (i > int'(nxt_idx)) begin
        nxt_hi = nxt_hi | nxt_map[i];
      end
    end
    nxt_vld  = nxt_map[nxt_idx];
    nxt_last = nxt_vld & ~nxt_hi;
  end

  // Frame sequencer with registered beat outputs and a single pending-request flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      y_q         <= '0;
      snap_q      <= '0;
      pending_q   <= 1'b0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      row_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            snap_q      <= in_rows;
            pending_q   <= 1'b0;
            y_q         <= '0;
            row_valid_q <= nxt_vld;
            row_data_q  <= nxt_row;
            row_last_q  <= nxt_last;
            state_q     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (frame_req) begin
            pending_q <= 1'b1;
          end
          if (advance) begin
            if (at_end) begin
              y_q         <= '0;
              row_valid_q <= 1'b0;
              row_data_q  <= '0;
              row_last_q  <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              y_q         <= nxt_idx;
              row_valid_q <= nxt_vld;
              row_data_q  <= nxt_row;
              row_last_q  <= nxt_last;
            end
          end
        end
        ST_DONE: begin
          if (frame_req) begin
            pending_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign row_valid  = row_valid_q;
  assign row_idx    = y_q;
  assign row_data   = row_data_q;
  assign row_last   = row_last_q;
  assign frame_done = done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
